segment_scan_ctrl: RTL and testbench
====================================

Name: segment_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It captures a hex word plus decimal points, enable mask and brightness through a load strobe. New data is applied only at frame boundaries, so the display never tears. Each frame cycles through the digits with per-slot PWM dimming and optional leading-zero blanking. It sits between the system datapath and the board display pins and contains its own hex-to-segment decode.

Parameters:
DIGITS, 8, number of digits scanned (1..16)
TICK, 100000, clock cycles per digit slot; must be a multiple of 8 and at least 8

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset
i_val  in  4*DIGITS  hex nibbles; nibble k drives digit k; digit 0 is rightmost (LSB)
i_dp  in  DIGITS  decimal point request per digit, 1 = lit
i_en  in  DIGITS  digit enable mask, 1 = digit may light
i_lzb  in  1  leading-zero blanking enable
i_bright  in  3  brightness, 0 = dimmest, 7 = full
i_load  in  1  single-cycle capture strobe for all i_* data inputs
o_seg  out  7  segments, active-low; bit0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle
o_dp  out  1  decimal point, active-low
o_an  out  DIGITS  anode select, active-low, at most one bit low
o_frame  out  1  one-cycle pulse when active data is refreshed (frame start)

Behaviour:
- One clock domain (i_clk). i_rst is synchronous and active-high.
- Reset values:
  - prescaler, slot index, shadow and active registers all 0.
  - o_seg = 7'b1111111, o_dp = 1, o_an = all 1, o_frame = 0.
  - Display stays dark until the first load propagates.
- Shadow registers (val, dp, en, lzb, bright):
  - Written on any cycle with i_load = 1.
  - Repeated loads within a frame: the last one wins.
- Prescaler cnt counts 0..TICK-1 and then wraps.
- Slot index:
  - Increments when cnt = TICK-1, wrapping DIGITS-1 -> 0.
  - Frame length is exactly DIGITS*TICK cycles.
  - Disabled or blanked digits still consume their slot, so the frame rate is constant.
- Frame boundary: the cycle where cnt = TICK-1 and slot = DIGITS-1.
  - active <= shadow on this cycle.
  - o_frame = 1 on the following cycle.
  - If i_load coincides with the boundary, active takes the pre-load shadow contents. The new data is shown one frame later; there is no bypass.
- PWM:
  - phase = cnt / (TICK/8), range 0..7.
  - The digit is lit while phase <= active bright.
  - bright = 7 gives 100% duty; bright = 0 gives 1/8.
- Leading-zero blanking (active lzb = 1):
  - Scan from digit DIGITS-1 downward.
  - A digit is blanked while its nibble = 0, its dp = 0, and no higher non-blanked digit exists.
  - Digit 0 is never blanked by LZB.
  - A digit with en = 0 does not stop the blanking chain.
- Lit condition for the current slot: en[slot] AND NOT lzb-blanked AND PWM on.
  - If lit: o_an = all 1 except bit slot = 0; o_seg = decode(nibble); o_dp = ~dp[slot].
  - If not lit: o_an = all 1, o_seg = all 1, o_dp = 1.
- Decode table, active-low, values 6..0:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Latency: all outputs are registered and lag the (cnt, slot) state by 1 cycle.
- Ghost prevention: o_an and o_seg change in the same cycle; o_an never has two bits low.
- i_rst asserted mid-frame: outputs go to reset values on the next edge, and scanning restarts at slot 0, cnt 0.

Test Plan:
- Reset, DIGITS=4, TICK=16, no load for 200 cycles -> o_an = 1111, o_seg = 1111111, o_dp = 1 throughout; o_frame pulses every 64 cycles.
- Load i_val = 0x12AF, i_en = 1111, i_bright = 7, i_dp = 0000 -> from the frame after the boundary:
  - slot 0: o_an = 1110, o_seg = 0001110
  - slot 1: o_an = 1101, o_seg = 0001000
  - slot 2: o_an = 1011, o_seg = 0100100
  - slot 3: o_an = 0111, o_seg = 1111001
  - each slot held 16 cycles.
- LZB cases, all with i_lzb = 1:
  - i_val = 0x0040 -> slots 3 and 2 dark; slot 1 o_seg = 0011001; slot 0 o_seg = 1000000.
  - i_val = 0x0000 -> only slot 0 lit, o_seg = 1000000.
  - i_dp = 1000 -> slot 3 lit with o_seg = 1000000, o_dp = 0.
- Brightness, TICK=16:
  - i_bright = 1 -> anode low for cnt 0..3 of each slot, high for cnt 4..15.
  - i_bright = 0 -> anode low for cnt 0..1 only.
- Tear-free load:
  - Load 0x5555 during slot 1 while 0x12AF is shown -> slots 1..3 keep old digits; 5 (0010010) appears from the next slot 0.
  - Load asserted on the boundary cycle -> new data appears one frame later.
- i_rst pulse during slot 2 -> next cycle all outputs are at reset values; after reset, scanning restarts at slot 0 with the display dark until a new load.

Source files
------------

// File: rtl/segment_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display.
// Data is double-buffered so a new word only takes effect at a frame boundary.
module segment_scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int TICK   = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*DIGITS-1:0]   i_val,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_en,
    input  logic                  i_lzb,
    input  logic [2:0]            i_bright,
    input  logic                  i_load,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [DIGITS-1:0]     o_an,
    output logic                  o_frame
);

    localparam int SUB  = TICK / 8;
    localparam int SUBW = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int SW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // The slot prescaler is split into a sub-count and a 3-bit PWM phase so the
    // phase is available directly, without dividing the count by TICK/8.
    logic [SUBW-1:0]       sub_q, sub_d;
    logic [2:0]            phase_q, phase_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic                  slotEnd, frameEnd;

    logic [4*DIGITS-1:0]   shadowVal_q, activeVal_q;
    logic [DIGITS-1:0]     shadowDp_q, activeDp_q;
    logic [DIGITS-1:0]     shadowEn_q, activeEn_q;
    logic                  shadowLzb_q, activeLzb_q;
    logic [2:0]            shadowBright_q, activeBright_q;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_q, frame_d;

    logic [DIGITS-1:0]     blank;
    logic                  chain;
    logic [3:0]            nibble;
    logic                  lit;

    function automatic logic [6:0] decodeHex(input logic [3:0] n);
        case (n)
            4'h0: decodeHex = 7'b1000000;
            4'h1: decodeHex = 7'b1111001;
            4'h2: decodeHex = 7'b0100100;
            4'h3: decodeHex = 7'b0110000;
            4'h4: decodeHex = 7'b0011001;
            4'h5: decodeHex = 7'b0010010;
            4'h6: decodeHex = 7'b0000010;
            4'h7: decodeHex = 7'b1111000;
            4'h8: decodeHex = 7'b0000000;
            4'h9: decodeHex = 7'b0010000;
            4'hA: decodeHex = 7'b0001000;
            4'hB: decodeHex = 7'b0000011;
            4'hC: decodeHex = 7'b1000110;
            4'hD: decodeHex = 7'b0100001;
            4'hE: decodeHex = 7'b0000110;
            4'hF: decodeHex = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        sub_d    = sub_q + 1'b1;
        phase_d  = phase_q;
        slot_d   = slot_q;
        slotEnd  = (phase_q == 3'd7) && (sub_q == SUBW'(SUB - 1));
        frameEnd = slotEnd && (slot_q == SW'(DIGITS - 1));
        if (sub_q == SUBW'(SUB - 1)) begin
            sub_d   = '0;
            phase_d = phase_q + 3'd1;
        end
        if (slotEnd) begin
            slot_d = frameEnd ? '0 : slot_q + 1'b1;
        end
    end

    // Disabled digits are transparent to the blanking chain; only a shown digit stops it.
    always_comb begin
        blank = '0;
        chain = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (activeLzb_q && chain && (activeVal_q[4*k +: 4] == 4'h0) && !activeDp_q[k]) begin
                blank[k] = 1'b1;
            end else if (activeEn_q[k]) begin
                chain = 1'b0;
            end
        end
    end

    always_comb begin
        nibble  = activeVal_q[4*slot_q +: 4];
        lit     = activeEn_q[slot_q] && !blank[slot_q] && (phase_q <= activeBright_q);
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        an_d    = '1;
        frame_d = frameEnd;
        if (lit) begin
            an_d[slot_q] = 1'b0;
            seg_d        = decodeHex(nibble);
            dp_d         = ~activeDp_q[slot_q];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sub_q          <= '0;
            phase_q        <= '0;
            slot_q         <= '0;
            shadowVal_q    <= '0;
            shadowDp_q     <= '0;
            shadowEn_q     <= '0;
            shadowLzb_q    <= 1'b0;
            shadowBright_q <= '0;
            activeVal_q    <= '0;
            activeDp_q     <= '0;
            activeEn_q     <= '0;
            activeLzb_q    <= 1'b0;
            activeBright_q <= '0;
            seg_q          <= 7'h7F;
            dp_q           <= 1'b1;
            an_q           <= '1;
            frame_q        <= 1'b0;
        end else begin
            sub_q   <= sub_d;
            phase_q <= phase_d;
            slot_q  <= slot_d;
            if (i_load) begin
                shadowVal_q    <= i_val;
                shadowDp_q     <= i_dp;
                shadowEn_q     <= i_en;
                shadowLzb_q    <= i_lzb;
                shadowBright_q <= i_bright;
            end
            if (frameEnd) begin
                activeVal_q    <= shadowVal_q;
                activeDp_q     <= shadowDp_q;
                activeEn_q     <= shadowEn_q;
                activeLzb_q    <= shadowLzb_q;
                activeBright_q <= shadowBright_q;
            end
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_dp    = dp_q;
    assign o_an    = an_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Scoreboard bench for segment_scan_ctrl with DIGITS=4, TICK=16 (64-cycle frames).
// Expected per-cycle outputs are queued when stimulus is issued; a monitor pops and compares.
module tb_segment_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int TICK   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] iVal = '0;
    logic [3:0]  iDp = '0;
    logic [3:0]  iEn = '0;
    logic        iLzb = 1'b0;
    logic [2:0]  iBright = '0;
    logic        iLoad = 1'b0;
    logic [6:0]  oSeg;
    logic        oDp;
    logic [3:0]  oAn;
    logic        oFrame;

    typedef struct {
        int         key;
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
        string      name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   kCnt = -1;

    always #5 clk = ~clk;

    segment_scan_ctrl #(.DIGITS(DIGITS), .TICK(TICK)) dut (
        .i_clk(clk), .i_rst(rst), .i_val(iVal), .i_dp(iDp), .i_en(iEn),
        .i_lzb(iLzb), .i_bright(iBright), .i_load(iLoad),
        .o_seg(oSeg), .o_dp(oDp), .o_an(oAn), .o_frame(oFrame)
    );

    // kCnt is the scan index whose outputs are visible at the following negedge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) kCnt <= -1;
        else     kCnt <= kCnt + 1;
    end

    task automatic pushRaw(input int key, input int k, input logic [3:0] an, input logic [6:0] seg,
                           input logic dp, input logic fr, input string name);
        exp_t e;
        e.key = key; e.k = k; e.an = an; e.seg = seg; e.dp = dp; e.fr = fr; e.name = name;
        q.push_back(e);
    endtask

    // Hand-supplied per-slot lit mask, segment codes {s3,s2,s1,s0} and dp mask.
    task automatic expectFrame(input int f, input logic [3:0] litMask, input logic [27:0] segs,
                               input logic [3:0] dpMask, input int onCnt, input string name);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 16; c++) begin
                int         k;
                logic       on;
                logic [3:0] an;
                k  = 64*f + 16*s + c;
                on = litMask[s] && (c < onCnt);
                an = on ? ~(4'b0001 << s) : 4'hF;
                pushRaw(cyc + (k - kCnt), k, an, on ? segs[7*s +: 7] : 7'h7F,
                        on ? ~dpMask[s] : 1'b1, (s == 3) && (c == 15), name);
            end
        end
    endtask

    task automatic checkOutput(input exp_t e);
        total++;
        if ({oAn, oSeg, oDp, oFrame} !== {e.an, e.seg, e.dp, e.fr}) begin
            bad++;
            $display("[TB] FAIL %s k=%0d: got an=%b seg=%b dp=%b frame=%b, want an=%b seg=%b dp=%b frame=%b",
                     e.name, e.k, oAn, oSeg, oDp, oFrame, e.an, e.seg, e.dp, e.fr);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].key < cyc) begin
                exp_t m;
                m = q.pop_front();
                total++;
                bad++;
                $display("[TB] FAIL %s k=%0d: sample missed, want an=%b seg=%b", m.name, m.k, m.an, m.seg);
            end
            if (q.size() > 0 && q[0].key == cyc) begin
                checkOutput(q.pop_front());
            end
        end
    end

    task automatic waitK(input int target);
        int n = 0;
        while (kCnt != target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (kCnt != target) begin
            total++;
            bad++;
            $display("[TB] FAIL waitK: got k=%0d, want k=%0d", kCnt, target);
        end
    endtask

    // Load is sampled on the posedge that produces scan index j.
    task automatic applyStimulus(input int j, input logic [15:0] val, input logic [3:0] dp,
                                 input logic [3:0] en, input logic lzb, input logic [2:0] bright);
        waitK(j - 1);
        iVal = val; iDp = dp; iEn = en; iLzb = lzb; iBright = bright;
        iLoad = 1'b1;
        @(negedge clk);
        iLoad = 1'b0;
    endtask

    localparam logic [27:0] SEG_12AF = {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110};
    localparam logic [27:0] SEG_5555 = {4{7'b0010010}};
    localparam logic [27:0] SEG_7777 = {4{7'b1111000}};
    localparam logic [27:0] SEG_0000 = {4{7'b1000000}};
    localparam logic [27:0] SEG_0040 = {7'b1000000, 7'b1000000, 7'b0011001, 7'b1000000};

    initial begin
        int n;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < 4; f++) expectFrame(f, 4'b0000, '0, 4'b0000, 0, "dark");

        applyStimulus(210, 16'h12AF, 4'b0000, 4'b1111, 1'b0, 3'd7);
        expectFrame(4, 4'b1111, SEG_12AF, 4'b0000, 16, "show12AF");
        expectFrame(5, 4'b1111, SEG_12AF, 4'b0000, 16, "tearOld");

        applyStimulus(340, 16'h5555, 4'b0000, 4'b1111, 1'b0, 3'd7);
        expectFrame(6, 4'b1111, SEG_5555, 4'b0000, 16, "tearNew");

        applyStimulus(447, 16'h7777, 4'b0000, 4'b1111, 1'b0, 3'd7);
        expectFrame(7, 4'b1111, SEG_5555, 4'b0000, 16, "bndOld");
        expectFrame(8, 4'b1111, SEG_7777, 4'b0000, 16, "bndNew");

        applyStimulus(580, 16'h0040, 4'b0000, 4'b1111, 1'b1, 3'd7);
        expectFrame(10, 4'b0011, SEG_0040, 4'b0000, 16, "lzb0040");

        applyStimulus(650, 16'h0000, 4'b0000, 4'b1111, 1'b1, 3'd7);
        expectFrame(11, 4'b0001, SEG_0000, 4'b0000, 16, "lzbZero");

        applyStimulus(720, 16'h0000, 4'b1000, 4'b1111, 1'b1, 3'd7);
        expectFrame(12, 4'b1111, SEG_0000, 4'b1000, 16, "lzbDp");

        applyStimulus(790, 16'h5040, 4'b0000, 4'b0111, 1'b1, 3'd7);
        expectFrame(13, 4'b0011, SEG_0040, 4'b0000, 16, "lzbDisabled");

        applyStimulus(860, 16'h12AF, 4'b0000, 4'b1111, 1'b0, 3'd1);
        expectFrame(14, 4'b1111, SEG_12AF, 4'b0000, 4, "bright1");

        applyStimulus(930, 16'h12AF, 4'b0000, 4'b1111, 1'b0, 3'd0);
        expectFrame(15, 4'b1111, SEG_12AF, 4'b0000, 2, "bright0");

        waitK(1055);
        rst = 1'b1;
        pushRaw(cyc + 1, 1056, 4'hF, 7'h7F, 1'b1, 1'b0, "midReset");
        @(negedge clk);
        rst = 1'b0;
        expectFrame(0, 4'b0000, '0, 4'b0000, 0, "postResetDark");
        applyStimulus(10, 16'h12AF, 4'b0000, 4'b1111, 1'b0, 3'd7);
        expectFrame(1, 4'b1111, SEG_12AF, 4'b0000, 16, "postResetShow");

        n = 0;
        while (q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
